// File: rtl/mem_if_pkg.sv
// Shared widths and the response record carried from the
// memory responder to its in-order response buffer.
package mem_if_pkg;

  localparam int MEM_AW = 3;
  localparam int MEM_DW = 32;

  typedef struct packed {
    logic              we;
    logic [MEM_DW-1:0] data;
  } mem_rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// In-order response buffer: DEPTH entries of mem_rsp_t.
// Ports: clk, rst (sync active-low), push/din, pop/dout,
// count (occupancy), empty.
module rsp_fifo
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  mem_rsp_t      din,
  input  logic          pop,
  output mem_rsp_t      dout,
  output logic [PW:0]   count,
  output logic          empty
);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  mem_rsp_t      slot_q [DEPTH];

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push) slot_q[wr_q] <= din;
  end

  assign dout  = slot_q[rd_q];
  assign count = cnt_q;
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Handshake-based 8x32 RAM responder with in-order responses.
// Ports: clk, rst (sync active-low), req_* channel, rsp_* channel.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int AW        = MEM_AW,
  parameter int DW        = MEM_DW,
  parameter int RSP_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_data
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic [DW-1:0] ram_q [2**AW];
  logic          accept;
  logic          pop;
  mem_rsp_t      push_rsp;
  mem_rsp_t      head;
  logic [CW-1:0] count;
  logic          empty;

  // Ready follows the registered count only: a pop in the
  // same cycle does not free a slot for a new request.
  assign req_ready = (count < CW'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign rsp_valid = ~empty;
  assign pop       = rsp_valid & rsp_ready;

  // Read data is taken before this edge's write lands.
  always_comb begin
    push_rsp.we   = req_we;
    push_rsp.data = req_we ? req_wdata : ram_q[req_addr];
  end

  // RAM is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (accept && req_we) ram_q[req_addr] <= req_wdata;
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .din   (push_rsp),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  // Stale slot contents are masked so outputs read 0 when idle.
  assign rsp_we   = rsp_valid & head.we;
  assign rsp_data = rsp_valid ? head.data : '0;

endmodule
